// File: rtl/teclado_clave.sv
// -----------------------------------------------------------------------------
// teclado_clave
// Keypad code-entry front end for the security system FSM. Collects digit
// keystrokes, compares the entered sequence against a fixed code and emits a
// one-cycle pw pulse on a match. Rejected attempts pulse pw_bad; MAX_FAIL
// consecutive rejections put the block into a LOCKOUT period of LOCK_CYCLES.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   key_valid  one-cycle strobe, key_code valid this cycle
//   key_code   0-9 digit, A clear, B enter, C-F ignored
//   pw         one-cycle pulse, correct code entered
//   pw_bad     one-cycle pulse, attempt rejected
//   locked     high for the whole lockout period
//   fail_cnt   consecutive failed attempts
//   digit_cnt  digits currently buffered (saturates at N_DIGITS)
//
// Optional feature: define TECLADO_TIMEOUT_EN to abort an entry after
// TIMEOUT_CYCLES cycles without a key; the timeout counts as a failed attempt.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the first digit
// ENTRY   | collecting digits until clear or enter
// CHECK   | one cycle: compare buffer with CODE, issue pw or pw_bad
// LOCKOUT | too many failures, all keys ignored until the counter expires
// -----------------------------------------------------------------------------
module teclado_clave #(
    parameter int          N_DIGITS       = 4,
    parameter logic [31:0] CODE           = 32'h0000_1234,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCK_CYCLES    = 16,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       pw,
    output logic       pw_bad,
    output logic       locked,
    output logic [2:0] fail_cnt,
    output logic [3:0] digit_cnt
);

    localparam int              BW         = N_DIGITS * 4;
    localparam logic [BW-1:0]   CODE_V     = CODE[BW-1:0];
    localparam logic [3:0]      N_DIG_V    = 4'(N_DIGITS);
    localparam logic [2:0]      MAX_FAIL_V = 3'(MAX_FAIL);
    localparam int              LCW        = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0]  LOCK_V     = LCW'(LOCK_CYCLES);

    typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCKOUT} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   dig_buf_q, dig_buf_d;
    logic [3:0]      digit_cnt_d;
    logic            ovf_q, ovf_d;
    logic [2:0]      fail_cnt_d;
    logic [LCW-1:0]  lock_cnt, lock_cnt_d;
    logic            pw_d, pw_bad_d, locked_d;

    logic            is_digit, is_clear, is_enter;
    logic            match, fail_evt, fail_trip, tmo_hit;
    logic [2:0]      fail_inc;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_clear  = key_valid && (key_code == 4'hA);
    assign is_enter  = key_valid && (key_code == 4'hB);

    // overflow forces a mismatch even if the first N digits were right
    assign match     = (digit_cnt == N_DIG_V) && !ovf_q && (dig_buf_q == CODE_V);
    assign fail_inc  = fail_cnt + 3'd1;
    assign fail_trip = (fail_inc == MAX_FAIL_V);
    assign fail_evt  = ((state == CHECK) && !match) || tmo_hit;

`ifdef TECLADO_TIMEOUT_EN
    localparam int             TCW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TMO_V = TCW'(TIMEOUT_CYCLES);

    logic [TCW-1:0] tmo_cnt;

    // reloads on every key seen in ENTRY (and on the digit that opens it);
    // terminal count 1 means this idle cycle is the TIMEOUT_CYCLES-th
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (((state == IDLE) && is_digit) || ((state == ENTRY) && key_valid)) begin
            tmo_cnt <= TMO_V;
        end else if ((state == ENTRY) && (tmo_cnt != '0)) begin
            tmo_cnt <= tmo_cnt - TCW'(1);
        end
    end

    assign tmo_hit = (state == ENTRY) && !key_valid && (tmo_cnt == TCW'(1));
`else
    assign tmo_hit = 1'b0;
`endif

    // state and registered datapath/outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dig_buf_q <= '0;
            digit_cnt <= '0;
            ovf_q     <= 1'b0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
            pw        <= 1'b0;
            pw_bad    <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            dig_buf_q <= dig_buf_d;
            digit_cnt <= digit_cnt_d;
            ovf_q     <= ovf_d;
            fail_cnt  <= fail_cnt_d;
            lock_cnt  <= lock_cnt_d;
            pw        <= pw_d;
            pw_bad    <= pw_bad_d;
            locked    <= locked_d;
        end
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_digit) state_nxt = ENTRY;
            end
            ENTRY: begin
                if (is_clear)      state_nxt = IDLE;
                else if (is_enter) state_nxt = CHECK;
                else if (tmo_hit)  state_nxt = fail_trip ? LOCKOUT : IDLE;
            end
            CHECK: begin
                if (match) state_nxt = IDLE;
                else       state_nxt = fail_trip ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                if (lock_cnt <= LCW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // next values of the datapath and the registered outputs
    always_comb begin
        dig_buf_d   = dig_buf_q;
        digit_cnt_d = digit_cnt;
        ovf_d       = ovf_q;
        fail_cnt_d  = fail_cnt;
        lock_cnt_d  = lock_cnt;
        pw_d        = 1'b0;
        pw_bad_d    = 1'b0;
        locked_d    = locked;

        case (state)
            IDLE: begin
                if (is_digit) begin
                    dig_buf_d   = BW'(key_code);
                    digit_cnt_d = 4'd1;
                    ovf_d       = 1'b0;
                end
            end
            ENTRY: begin
                if (is_digit) begin
                    if (digit_cnt < N_DIG_V) begin
                        dig_buf_d   = (dig_buf_q << 4) | BW'(key_code);
                        digit_cnt_d = digit_cnt + 4'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (is_clear || tmo_hit) begin
                    dig_buf_d   = '0;
                    digit_cnt_d = '0;
                    ovf_d       = 1'b0;
                end
            end
            CHECK: begin
                dig_buf_d   = '0;
                digit_cnt_d = '0;
                ovf_d       = 1'b0;
                if (match) begin
                    pw_d       = 1'b1;
                    fail_cnt_d = '0;
                end
            end
            LOCKOUT: begin
                if (lock_cnt <= LCW'(1)) begin
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                    fail_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt - LCW'(1);
                end
            end
            default: ;
        endcase

        // shared rejection path for a bad CHECK and an entry timeout
        if (fail_evt) begin
            pw_bad_d   = 1'b1;
            fail_cnt_d = fail_inc;
            if (fail_trip) begin
                locked_d   = 1'b1;
                lock_cnt_d = LOCK_V;
            end
        end
    end

endmodule
